// File: rtl/czonotope_serializer_if.sv
// Constrained-zonotope container: dimensions plus center, generator, constraint and rhs arrays.
// A loader drives it through master; readers such as the serializer use slave.
interface CZonotope #(
    parameter int DATA_WIDTH = 32,
    parameter int NMAX       = 10,
    parameter int NGMAX      = 5,
    parameter int NCMAX      = 3,
    parameter int DIM_W      = 8
) ();
    logic [DIM_W-1:0]      n;
    logic [DIM_W-1:0]      ng;
    logic [DIM_W-1:0]      nc;
    logic [DATA_WIDTH-1:0] c [NMAX];
    logic [DATA_WIDTH-1:0] G [NMAX][NGMAX];
    logic [DATA_WIDTH-1:0] A [NCMAX][NGMAX];
    logic [DATA_WIDTH-1:0] b [NCMAX];

    modport master (output n, ng, nc, c, G, A, b);
    modport slave  (input  n, ng, nc, c, G, A, b);
endinterface

// File: rtl/czonotope_serializer.sv
// Drains a CZonotope as header, c, G, A, b words over a valid/ready stream.
// Output registers always hold the word at (state,row,col); a handshake loads the next one.
module czonotope_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int NMAX       = 10,
    parameter int NGMAX      = 5,
    parameter int NCMAX      = 3,
    parameter int DIM_W      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    CZonotope.slave               Z,
    output logic [DATA_WIDTH-1:0] tdata_o,
    output logic [2:0]            tag_o,
    output logic                  tvalid_o,
    input  logic                  tready_i,
    output logic                  tlast_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int RW   = $clog2(((NMAX > NCMAX) ? NMAX : NCMAX) + 1);
    localparam int CW   = $clog2(((NMAX > NGMAX) ? NMAX : NGMAX) + 1);
    localparam int CI_W = (NMAX  > 1) ? $clog2(NMAX)  : 1;
    localparam int GJ_W = (NGMAX > 1) ? $clog2(NGMAX) : 1;
    localparam int AR_W = (NCMAX > 1) ? $clog2(NCMAX) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_CEN  = 3'd2;
    localparam logic [2:0] S_GEN  = 3'd3;
    localparam logic [2:0] S_CON  = 3'd4;
    localparam logic [2:0] S_RHS  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]            state, nxt_state;
    logic [2:0]            aft_hdr, aft_cen, aft_gen, aft_con, nxt_follow;
    logic [RW-1:0]         row, nxt_row;
    logic [CW-1:0]         col, nxt_col;
    logic [DIM_W-1:0]      n_q, ng_q, nc_q;
    logic [DIM_W-1:0]      n_cl, ng_cl, nc_cl;
    logic [DIM_W-1:0]      row_x, col_x, nrow_x, ncol_x;
    logic                  clamp, nxt_end, nxt_last;
    logic [DATA_WIDTH-1:0] nxt_data;
    logic [2:0]            nxt_tag;

    always_comb begin
        n_cl  = (Z.n  > DIM_W'(NMAX))  ? DIM_W'(NMAX)  : Z.n;
        ng_cl = (Z.ng > DIM_W'(NGMAX)) ? DIM_W'(NGMAX) : Z.ng;
        nc_cl = (Z.nc > DIM_W'(NCMAX)) ? DIM_W'(NCMAX) : Z.nc;
        clamp = (Z.n > DIM_W'(NMAX)) || (Z.ng > DIM_W'(NGMAX)) || (Z.nc > DIM_W'(NCMAX));
    end

    // Successor of each section, skipping the empty ones so there is no bubble.
    always_comb begin
        aft_con = (nc_q != '0) ? S_RHS : S_DONE;
        aft_gen = (nc_q != '0 && ng_q != '0) ? S_CON : aft_con;
        aft_cen = (n_q  != '0 && ng_q != '0) ? S_GEN : aft_gen;
        aft_hdr = (n_q  != '0) ? S_CEN : aft_cen;
    end

    assign row_x  = DIM_W'(row);
    assign col_x  = DIM_W'(col);
    assign nrow_x = DIM_W'(nxt_row);
    assign ncol_x = DIM_W'(nxt_col);

    always_comb begin
        nxt_state = state;
        nxt_row   = row;
        nxt_col   = col;
        case (state)
            S_HDR: begin
                if (col_x == DIM_W'(2)) begin
                    nxt_state = aft_hdr;
                    nxt_col   = '0;
                end else begin
                    nxt_col = col + CW'(1);
                end
            end
            S_CEN: begin
                if (col_x == n_q - DIM_W'(1)) begin
                    nxt_state = aft_cen;
                    nxt_col   = '0;
                end else begin
                    nxt_col = col + CW'(1);
                end
            end
            S_GEN, S_CON: begin
                if (col_x == ng_q - DIM_W'(1)) begin
                    nxt_col = '0;
                    if (row_x == ((state == S_GEN) ? n_q : nc_q) - DIM_W'(1)) begin
                        nxt_state = (state == S_GEN) ? aft_gen : aft_con;
                        nxt_row   = '0;
                    end else begin
                        nxt_row = row + RW'(1);
                    end
                end else begin
                    nxt_col = col + CW'(1);
                end
            end
            S_RHS: begin
                if (row_x == nc_q - DIM_W'(1)) begin
                    nxt_state = S_DONE;
                    nxt_row   = '0;
                end else begin
                    nxt_row = row + RW'(1);
                end
            end
            default: ;
        endcase
    end

    // Word at the next position, plus whether it ends the whole transfer.
    always_comb begin
        nxt_data   = '0;
        nxt_tag    = 3'd0;
        nxt_end    = 1'b0;
        nxt_follow = S_DONE;
        case (nxt_state)
            S_HDR: begin
                nxt_tag    = 3'd0;
                nxt_data   = (ncol_x == DIM_W'(1)) ? DATA_WIDTH'(ng_q) : DATA_WIDTH'(nc_q);
                nxt_end    = (ncol_x == DIM_W'(2));
                nxt_follow = aft_hdr;
            end
            S_CEN: begin
                nxt_tag    = 3'd1;
                nxt_data   = Z.c[nxt_col[CI_W-1:0]];
                nxt_end    = (ncol_x == n_q - DIM_W'(1));
                nxt_follow = aft_cen;
            end
            S_GEN: begin
                nxt_tag    = 3'd2;
                nxt_data   = Z.G[nxt_row[CI_W-1:0]][nxt_col[GJ_W-1:0]];
                nxt_end    = (nrow_x == n_q - DIM_W'(1)) && (ncol_x == ng_q - DIM_W'(1));
                nxt_follow = aft_gen;
            end
            S_CON: begin
                nxt_tag    = 3'd3;
                nxt_data   = Z.A[nxt_row[AR_W-1:0]][nxt_col[GJ_W-1:0]];
                nxt_end    = (nrow_x == nc_q - DIM_W'(1)) && (ncol_x == ng_q - DIM_W'(1));
                nxt_follow = aft_con;
            end
            S_RHS: begin
                nxt_tag    = 3'd4;
                nxt_data   = Z.b[nxt_row[AR_W-1:0]];
                nxt_end    = (nrow_x == nc_q - DIM_W'(1));
                nxt_follow = S_DONE;
            end
            default: ;
        endcase
        nxt_last = nxt_end && (nxt_follow == S_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            row      <= '0;
            col      <= '0;
            n_q      <= '0;
            ng_q     <= '0;
            nc_q     <= '0;
            tdata_o  <= '0;
            tag_o    <= 3'd0;
            tvalid_o <= 1'b0;
            tlast_o  <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        state    <= S_HDR;
                        row      <= '0;
                        col      <= '0;
                        n_q      <= n_cl;
                        ng_q     <= ng_cl;
                        nc_q     <= nc_cl;
                        err_o    <= clamp;
                        busy_o   <= 1'b1;
                        tvalid_o <= 1'b1;
                        tdata_o  <= DATA_WIDTH'(n_cl);
                        tag_o    <= 3'd0;
                        tlast_o  <= 1'b0;
                    end
                end
                S_DONE: begin
                    done_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    if (tvalid_o && tready_i) begin
                        state <= nxt_state;
                        row   <= nxt_row;
                        col   <= nxt_col;
                        if (nxt_state == S_DONE) begin
                            tvalid_o <= 1'b0;
                            tlast_o  <= 1'b0;
                            busy_o   <= 1'b0;
                            done_o   <= 1'b1;
                        end else begin
                            tdata_o <= nxt_data;
                            tag_o   <= nxt_tag;
                            tlast_o <= nxt_last;
                        end
                    end
                end
            endcase
        end
    end
endmodule
